// File: rtl/password_programmer.sv
// Password-programming controller: collects a DIGITS-long code, optionally
// confirms it (PWSET_CONFIRM_EN), then commits it one address per cycle.
module password_programmer #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    localparam int AW     = $clog2(DIGITS)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               cancel,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DIGIT_W-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               mismatch,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTER   = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DIGITS - 1);

    state_t             state;
    state_t             state_next;
    logic [AW-1:0]      idx;
    logic [DIGIT_W-1:0] stage_buf [DIGITS];
    logic               at_last;
    logic               take;

    assign at_last = (idx == LAST);
    // cancel has priority over a digit strobed in the same cycle
    assign take    = digit_valid && !cancel;

`ifdef PWSET_CONFIRM_EN
    logic err;
    logic digit_bad;

    assign digit_bad = (digit != stage_buf[idx]);
`endif

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no latch is inferred
    // for states or conditions that do not assign it.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ENTER;
                end
            end
            ST_ENTER: begin
                if (cancel) begin
                    state_next = ST_IDLE;
                end else if (digit_valid && at_last) begin
`ifdef PWSET_CONFIRM_EN
                    state_next = ST_CONFIRM;
`else
                    state_next = ST_COMMIT;
`endif
                end
            end
`ifdef PWSET_CONFIRM_EN
            ST_CONFIRM: begin
                if (cancel) begin
                    state_next = ST_IDLE;
                end else if (digit_valid && at_last) begin
                    state_next = (err || digit_bad) ? ST_FAIL : ST_COMMIT;
                end
            end
            ST_FAIL: begin
                state_next = ST_IDLE;
            end
`endif
            ST_COMMIT: begin
                if (at_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Digit / address index, shared by entry, confirmation and commit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx <= '0;
                    end
                end
                ST_ENTER, ST_CONFIRM: begin
                    if (cancel) begin
                        idx <= '0;
                    end else if (digit_valid) begin
                        idx <= at_last ? '0 : idx + AW'(1);
                    end
                end
                ST_COMMIT: begin
                    idx <= at_last ? '0 : idx + AW'(1);
                end
                default: begin
                    idx <= idx;
                end
            endcase
        end
    end

    // NOTE: the staging buffer is a small flop array with a defined all-zero
    // reset value, so it is reset like any other register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DIGITS; i++) begin
                stage_buf[i] <= '0;
            end
        end else if (state == ST_ENTER && take) begin
            stage_buf[idx] <= digit;
        end
    end

`ifdef PWSET_CONFIRM_EN
    // Sticky compare error; resolved when the last confirm digit arrives.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err <= 1'b0;
        end else begin
            case (state)
                ST_CONFIRM: begin
                    if (cancel) begin
                        err <= 1'b0;
                    end else if (digit_valid) begin
                        err <= err | digit_bad;
                    end
                end
                ST_FAIL: begin
                    err <= 1'b0;
                end
                default: begin
                    err <= err;
                end
            endcase
        end
    end
`endif

    // Moore outputs; the write port is quiet outside COMMIT.
    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        mismatch  = 1'b0;
        dbg_state = state;
        case (state)
            ST_ENTER, ST_CONFIRM: begin
                busy = 1'b1;
            end
            ST_COMMIT: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = idx;
                wr_data = stage_buf[idx];
            end
            ST_DONE: begin
                done = 1'b1;
            end
`ifdef PWSET_CONFIRM_EN
            ST_FAIL: begin
                mismatch = 1'b1;
            end
`endif
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_password_programmer.sv
// Randomised self-checking bench for password_programmer; adapts to whether
// PWSET_CONFIRM_EN is defined (4x4-bit code with confirm, 6x8-bit without).
module tb_password_programmer;

`ifdef PWSET_CONFIRM_EN
    localparam int D  = 4;
    localparam int DW = 4;
`else
    localparam int D  = 6;
    localparam int DW = 8;
`endif
    localparam int AW = $clog2(D);

    typedef logic [DW-1:0] code_t [D];
    typedef struct {
        int c;
        int a;
        int d;
    } wr_t;

    logic          CLK;
    logic          RST;
    logic          start;
    logic          cancel;
    logic          digit_valid;
    logic [DW-1:0] digit;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          mismatch;
    logic [2:0]    dbg_state;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    wr_t   wq[$];
    int    done_c[$];
    bit    done_busy[$];
    int    mm_c[$];
    code_t store_act;
    code_t store_exp;

    password_programmer #(.DIGITS(D), .DIGIT_W(DW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .cancel(cancel),
        .digit_valid(digit_valid), .digit(digit),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .mismatch(mismatch), .dbg_state(dbg_state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Passive monitor: the password store and pulse history as the outside world sees them.
    always @(negedge CLK) begin
        if (wr_en === 1'b1) begin
            wq.push_back('{cyc, int'(wr_addr), int'(wr_data)});
            if (int'(wr_addr) < D) store_act[int'(wr_addr)] <= wr_data;
        end
        if (done === 1'b1) begin
            done_c.push_back(cyc);
            done_busy.push_back(busy);
        end
        if (mismatch === 1'b1) mm_c.push_back(cyc);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete();
        done_c.delete();
        done_busy.delete();
        mm_c.delete();
    endtask

    function automatic code_t rand_code();
        code_t r;
        for (int i = 0; i < D; i++) r[i] = DW'($urandom);
        return r;
    endfunction

    function automatic code_t seq_code(input int base);
        code_t r;
        for (int i = 0; i < D; i++) r[i] = DW'(base + i);
        return r;
    endfunction

    function automatic code_t corrupt(input code_t a);
        code_t r;
        int    p;
        r    = a;
        p    = $urandom_range(0, D - 1);
        r[p] = a[p] ^ DW'($urandom_range(1, (1 << DW) - 1));
        return r;
    endfunction

    task automatic check_quiet(input string name);
        logic [63:0] o;
        o = 64'({wr_en, wr_addr, wr_data, busy, done, mismatch, dbg_state});
        n_vec++;
        if (o !== 64'd0) begin
            n_err++;
            $display("FAIL %s: outputs=%h required all zero", name, o);
        end
    endtask

    task automatic check_state(input string name, input logic [2:0] exp);
        n_vec++;
        if (dbg_state !== exp) begin
            n_err++;
            $display("FAIL %s: dbg_state=%0d required %0d (cyc %0d)", name, dbg_state, exp, cyc);
        end
    endtask

    task automatic check_store(input string name);
        n_vec++;
        if (store_act != store_exp) begin
            n_err++;
            for (int i = 0; i < D; i++)
                if (store_act[i] !== store_exp[i]) begin
                    $display("FAIL %s: store[%0d]=%h required %h", name, i, store_act[i], store_exp[i]);
                    break;
                end
        end
    endtask

    task automatic enter_code(input code_t c, input bit gaps);
        for (int i = 0; i < D; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            digit_valid = 1'b1;
            digit       = c[i];
            step();
            digit_valid = 1'b0;
        end
    endtask

    // Full session; k is the cycle count right after the edge that took the final digit.
    task automatic do_session(input code_t a, input code_t b, input bit gaps, output int k);
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        enter_code(a, gaps);
`ifdef PWSET_CONFIRM_EN
        enter_code(b, gaps);
`endif
        k = cyc;
    endtask

    // Reference outcome: matching entries commit the code in order, otherwise only a mismatch pulse.
    task automatic check_outcome(input string name, input code_t a, input code_t b, input int k);
        bit match;
`ifdef PWSET_CONFIRM_EN
        match = (a == b);
`else
        match = 1'b1;
`endif
        repeat (D + 2) step();
        if (match) begin
            n_vec++;
            if (wq.size() != D) begin
                n_err++;
                $display("FAIL %s writes: count=%0d required %0d", name, wq.size(), D);
            end
            for (int i = 0; i < D && i < wq.size(); i++) begin
                n_vec++;
                if (wq[i].c != k + i || wq[i].a != i || wq[i].d != int'(a[i])) begin
                    n_err++;
                    $display("FAIL %s write%0d: cyc/addr/data=%0d/%0d/%h required %0d/%0d/%h",
                             name, i, wq[i].c, wq[i].a, wq[i].d, k + i, i, a[i]);
                end
            end
            n_vec++;
            if (done_c.size() != 1 || done_c[0] != k + D || done_busy[0] !== 1'b0) begin
                n_err++;
                $display("FAIL %s done: pulses=%0d first_cyc=%0d required 1 at %0d with busy low",
                         name, done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, k + D);
            end
            n_vec++;
            if (mm_c.size() != 0) begin
                n_err++;
                $display("FAIL %s mismatch: pulses=%0d required 0", name, mm_c.size());
            end
            store_exp = a;
        end else begin
            n_vec++;
            if (wq.size() != 0 || done_c.size() != 0) begin
                n_err++;
                $display("FAIL %s nowrite: writes=%0d done=%0d required 0/0", name, wq.size(), done_c.size());
            end
            n_vec++;
            if (mm_c.size() != 1 || mm_c[0] != k) begin
                n_err++;
                $display("FAIL %s mismatch: pulses=%0d first_cyc=%0d required 1 at %0d",
                         name, mm_c.size(), (mm_c.size() > 0) ? mm_c[0] : -1, k);
            end
        end
        check_state({name, " idle"}, 3'd0);
        check_store(name);
    endtask

    task automatic test_reset();
        RST = 1'b0; start = 1'b0; cancel = 1'b0; digit_valid = 1'b0; digit = '0;
        for (int i = 0; i < D; i++) begin
            store_act[i] = '0;
            store_exp[i] = '0;
        end
        #2 RST = 1'b1;
        repeat (2) step();
        check_quiet("reset_held");
        RST = 1'b0;
        #2 check_quiet("reset_first_cycle");
        step();
    endtask

    task automatic test_commit();
        int k;
        do_session(seq_code(1), seq_code(1), 1'b0, k);
        check_outcome("commit_seq", seq_code(1), seq_code(1), k);
    endtask

    task automatic test_mismatch();
`ifdef PWSET_CONFIRM_EN
        int    k;
        code_t b;
        b    = seq_code(1);
        b[2] = DW'(9);
        do_session(seq_code(1), b, 1'b0, k);
        check_outcome("mismatch_fixed", seq_code(1), b, k);
`endif
    endtask

    task automatic test_cancel();
        int k;
        clear_mon();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            digit_valid = 1'b1; digit = DW'($urandom); step();
        end
        digit_valid = 1'b0;
        cancel = 1'b1; step(); cancel = 1'b0;
        check_state("cancel_enter", 3'd0);
        start = 1'b1; step(); start = 1'b0;
        digit_valid = 1'b1; digit = DW'($urandom); step();
        cancel = 1'b1; step();
        cancel = 1'b0; digit_valid = 1'b0;
        check_state("cancel_with_digit", 3'd0);
`ifdef PWSET_CONFIRM_EN
        start = 1'b1; step(); start = 1'b0;
        enter_code(rand_code(), 1'b0);
        digit_valid = 1'b1; digit = DW'($urandom); step();
        digit_valid = 1'b0;
        cancel = 1'b1; step(); cancel = 1'b0;
        check_state("cancel_confirm", 3'd0);
`endif
        step();
        n_vec++;
        if (wq.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL cancel_quiet: writes=%0d busy=%b required 0/0", wq.size(), busy);
        end
        do_session(seq_code(5), seq_code(5), 1'b0, k);
        check_outcome("after_cancel", seq_code(5), seq_code(5), k);
    endtask

    task automatic test_reset_mid_commit();
        int    k;
        code_t a;
        a = rand_code();
        do_session(a, a, 1'b0, k);
        step();
        #5;
        RST = 1'b1;
        #1 check_quiet("rst_mid_commit");
        n_vec++;
        if (wq.size() != 2 || wq[0].d != int'(a[0]) || wq[1].a != 1 || wq[1].d != int'(a[1])) begin
            n_err++;
            $display("FAIL rst_partial: writes=%0d required 2 (addr 0,1)", wq.size());
        end
        store_exp[0] = a[0];
        store_exp[1] = a[1];
        repeat (2) step();
        check_quiet("rst_mid_held");
        RST = 1'b0;
        #2 check_quiet("rst_mid_release");
        step();
        a = rand_code();
        do_session(a, a, 1'b1, k);
        check_outcome("after_rst", a, a, k);
    endtask

    task automatic test_commit_atomic();
        int    k;
        code_t a;
        a = rand_code();
        do_session(a, a, 1'b0, k);
        for (int j = 1; j < D; j++) begin
            start = 1'b1; cancel = 1'b1; digit_valid = 1'b1; digit = DW'($urandom);
            step();
        end
        start = 1'b0; cancel = 1'b0; digit_valid = 1'b0;
        cyc_wait_adjust(k, a);
    endtask

    // Writes already seen during the held-input phase stay in the monitor queue.
    task automatic cyc_wait_adjust(input int k, input code_t a);
        repeat (3) step();
        n_vec++;
        if (wq.size() != D || done_c.size() != 1 || done_c[0] != k + D) begin
            n_err++;
            $display("FAIL atomic_commit: writes=%0d done=%0d required %0d/1 at %0d",
                     wq.size(), done_c.size(), D, k + D);
        end
        for (int i = 0; i < D && i < wq.size(); i++) begin
            n_vec++;
            if (wq[i].a != i || wq[i].d != int'(a[i]) || wq[i].c != k + i) begin
                n_err++;
                $display("FAIL atomic_write%0d: addr/data=%0d/%h required %0d/%h", i, wq[i].a, wq[i].d, i, a[i]);
            end
        end
        store_exp = a;
        check_state("atomic_idle", 3'd0);
        check_store("atomic_store");
    endtask

    task automatic test_start_held();
        int         k;
        code_t      a;
        logic [2:0] exp;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            digit_valid = 1'b1; digit = DW'($urandom); step();
        end
        digit_valid = 1'b0;
        n_vec++;
        if (dbg_state !== 3'd0 || busy !== 1'b0 || wq.size() != 0) begin
            n_err++;
            $display("FAIL idle_strobes: dbg_state=%0d busy=%b required 0/0", dbg_state, busy);
        end
        a = rand_code();
        start = 1'b1; step();
        enter_code(a, 1'b0);
`ifdef PWSET_CONFIRM_EN
        enter_code(a, 1'b0);
`endif
        k = cyc;
        for (int j = 1; j <= D + 2; j++) begin
            digit_valid = (j <= D + 1);
            digit       = DW'($urandom);
            step();
            exp = (j < D) ? 3'd3 : (j == D) ? 3'd4 : (j == D + 1) ? 3'd0 : 3'd1;
            check_state($sformatf("held_done_j%0d", j), exp);
        end
        digit_valid = 1'b0; start = 1'b0; cancel = 1'b1; step(); cancel = 1'b0;
        n_vec++;
        if (wq.size() != D || done_c.size() != 1) begin
            n_err++;
            $display("FAIL held_commit: writes=%0d done=%0d required %0d/1", wq.size(), done_c.size(), D);
        end
        store_exp = a;
        check_store("held_store");
`ifdef PWSET_CONFIRM_EN
        clear_mon();
        start = 1'b1; step();
        enter_code(a, 1'b0);
        enter_code(corrupt(a), 1'b0);
        check_state("held_fail", 3'd5);
        digit_valid = 1'b1; digit = DW'($urandom); step();
        digit_valid = 1'b0;
        check_state("held_fail_idle", 3'd0);
        step();
        check_state("held_fail_rearm", 3'd1);
        start = 1'b0; cancel = 1'b1; step(); cancel = 1'b0;
        n_vec++;
        if (wq.size() != 0 || mm_c.size() != 1) begin
            n_err++;
            $display("FAIL held_fail_pulse: writes=%0d mismatch=%0d required 0/1", wq.size(), mm_c.size());
        end
        check_store("held_fail_store");
`endif
    endtask

    task automatic test_back_to_back();
        int    k;
        code_t a;
        code_t b;
        for (int s = 0; s < 16; s++) begin
            a = rand_code();
            b = ($urandom_range(0, 2) == 0) ? corrupt(a) : a;
            do_session(a, b, s[0], k);
            check_outcome($sformatf("random_%0d", s), a, b, k);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_mismatch();
        test_cancel();
        test_reset_mid_commit();
        test_commit_atomic();
        test_start_held();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
